adder_share_arbiter: RTL and testbench

- Shares one combinational ripple_adder instance between NUM_REQ requesters.
- Each requester presents two operands with a valid/ready handshake. The block grants one requester round-robin, registers its operands, computes the WIDTH+1-bit sum, and returns it with the requester ID on a single valid/ready response channel.
- Sits between the operand-producing units and the shared adder datapath.

---
 rtl/adder_share_pkg.sv | 15 +
 rtl/adder_share_arbiter_rr_arbiter.sv | 36 +++
 rtl/ripple_adder.sv | 23 ++
 rtl/adder_share_arbiter.sv | 138 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter and its round-robin picker.
package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int calc_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after the last grant, wrapping.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = calc_id_w(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_last_grant,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_grant_idx,
  output logic            o_any
);

  int              w_idx;
  logic [ID_W-1:0] w_sel;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = 0;
    w_sel       = '0;
    // Offset N revisits the last grantee itself, so it wins only when it is alone.
    for (int off = 1; off <= N; off++) begin
      w_idx = (int'(i_last_grant) + off) % N;
      w_sel = ID_W'(w_idx);
      if (!o_any && i_req[w_sel]) begin
        o_any          = 1'b1;
        o_grant_idx    = w_sel;
        o_grant[w_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ripple_adder.sv
// Combinational ripple-carry adder shared by all requesters.
module ripple_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one ripple adder among NUM_REQ requesters with round-robin grant and a
// single registered valid/ready response channel carrying the owner ID.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter  int WIDTH   = 64,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_add1,
  input  logic [NUM_REQ*WIDTH-1:0] i_add2,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [WIDTH:0]           o_rsp_result,
  input  logic                     i_rsp_ready
);

  state_t            r_state;
  state_t            w_next_state;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_id;
  logic [WIDTH-1:0]  r_op1;
  logic [WIDTH-1:0]  r_op2;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [WIDTH:0]    r_rsp_result;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any;
  logic [WIDTH-1:0]   w_sel_add1;
  logic [WIDTH-1:0]   w_sel_add2;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .i_req        (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any)
  );

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_ripple_adder (
    .i_a    (r_op1),
    .i_b    (r_op2),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_sel_add1 = '0;
    w_sel_add2 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_idx == ID_W'(k)) begin
        w_sel_add1 = i_add1[k*WIDTH +: WIDTH];
        w_sel_add2 = i_add2[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ready is decoded from state alone, so i_rsp_ready never reaches o_req_ready.
  always_comb begin
    w_next_state = r_state;
    o_req_ready  = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          o_req_ready  = w_grant;
          w_next_state = CALC;
        end
      end
      CALC: w_next_state = RESP;
      RESP: begin
        if (i_rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op1        <= w_sel_add1;
            r_op2        <= w_sel_add2;
            r_id         <= w_grant_idx;
            r_last_grant <= w_grant_idx;
          end
        end
        CALC: begin
          r_rsp_result <= {w_cout, w_sum};
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter at WIDTH=8, NUM_REQ=4.
module tb_adder_share_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic [NUM_REQ*WIDTH-1:0] i_add1;
  logic [NUM_REQ*WIDTH-1:0] i_add2;
  logic                     o_rsp_valid;
  logic [ID_W-1:0]          o_rsp_id;
  logic [WIDTH:0]           o_rsp_result;
  logic                     i_rsp_ready;

  int checks;
  int failures;

  adder_share_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_add1       (i_add1),
    .i_add2       (i_add2),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .i_rsp_ready  (i_rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    i_add1[k*WIDTH +: WIDTH] = a;
    i_add2[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    i_req_valid = '0;
    i_add1      = '0;
    i_add2      = '0;
    i_rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({o_rsp_valid, o_rsp_id, o_rsp_result, o_req_ready} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b id=%0d result=%h ready=%b required all zero",
               o_rsp_valid, o_rsp_id, o_rsp_result, o_req_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle: valid=%0b ready=%b required 0 and 0000", o_rsp_valid, o_req_ready);
    end
  endtask

  task automatic test_single();
    set_ops(1, 8'h7F, 8'h01);
    i_rsp_ready = 1'b1;
    i_req_valid = 4'b0010;
    #1;
    checks++;
    if (o_req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL single_ready: got %b required 0010", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_calc_valid: got %0b required 0", o_rsp_valid);
    end
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd1 || o_rsp_result !== 9'h080) begin
      failures++;
      $display("FAIL single_rsp: valid=%0b id=%0d result=%h required 1 1 080",
               o_rsp_valid, o_rsp_id, o_rsp_result);
    end
    tick();
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_handshake: valid=%0b required 0", o_rsp_valid);
    end
  endtask

  task automatic test_carry();
    set_ops(0, 8'hFF, 8'hFF);
    i_req_valid = 4'b0001;
    #1;
    checks++;
    if (o_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL carry_ready: got %b required 0001", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_result !== 9'h1FE) begin
      failures++;
      $display("FAIL carry_rsp: valid=%0b id=%0d result=%h required 1 0 1fe",
               o_rsp_valid, o_rsp_id, o_rsp_result);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [8:0] rr_res [4];
    logic [3:0] exp_gnt;
    int grants;
    int rsps;
    int last_cyc;
    rr_res[0] = 9'h0F1;
    rr_res[1] = 9'h101;
    rr_res[2] = 9'h111;
    rr_res[3] = 9'h121;
    grants   = 0;
    rsps     = 0;
    last_cyc = 0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < NUM_REQ; k++) begin
      set_ops(k, 8'(16 * k + 1), 8'hF0);
    end
    i_rsp_ready = 1'b1;
    i_req_valid = 4'b1111;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      checks++;
      if ($countones(o_req_ready) > 1) begin
        failures++;
        $display("FAIL rr_onehot: ready=%b required at most one bit", o_req_ready);
      end
      if (o_req_ready !== 4'b0000 && grants < 6) begin
        exp_gnt = 4'b0001 << (grants % 4);
        checks++;
        if (o_req_ready !== exp_gnt) begin
          failures++;
          $display("FAIL rr_grant_order: grant %0d got %b required %b", grants, o_req_ready, exp_gnt);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            failures++;
            $display("FAIL rr_interval: got %0d cycles required 3", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        grants++;
      end
      if (o_rsp_valid === 1'b1 && rsps < 6) begin
        checks++;
        if (o_rsp_id !== 2'(rsps % 4) || o_rsp_result !== rr_res[rsps % 4]) begin
          failures++;
          $display("FAIL rr_rsp: rsp %0d id=%0d result=%h required id=%0d result=%h",
                   rsps, o_rsp_id, o_rsp_result, rsps % 4, rr_res[rsps % 4]);
        end
        rsps++;
      end
      tick();
      if (grants >= 6) i_req_valid = '0;
      if (rsps >= 6) break;
    end
    checks++;
    if (rsps != 6) begin
      failures++;
      $display("FAIL rr_timeout: got %0d responses required 6", rsps);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] held_res;
    logic [1:0] held_id;
    i_rsp_ready = 1'b0;
    set_ops(3, 8'h12, 8'h34);
    set_ops(0, 8'h0A, 8'h05);
    i_req_valid = 4'b1000;
    #1;
    checks++;
    if (o_req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_ready: got %b required 1000", o_req_ready);
    end
    tick();
    i_req_valid = 4'b0001;
    checks++;
    if (o_req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL bp_calc_ready: got %b required 0000", o_req_ready);
    end
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd3 || o_rsp_result !== 9'h046) begin
      failures++;
      $display("FAIL bp_rsp: valid=%0b id=%0d result=%h required 1 3 046",
               o_rsp_valid, o_rsp_id, o_rsp_result);
    end
    held_res = 9'h046;
    held_id  = 2'd3;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_id !== held_id || o_rsp_result !== held_res ||
          o_req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d valid=%0b id=%0d result=%h ready=%b required 1 3 046 0000",
                 c, o_rsp_valid, o_rsp_id, o_rsp_result, o_req_ready);
      end
    end
    i_rsp_ready = 1'b1;
    tick();
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bp_next_grant: valid=%0b ready=%b required 0 0001", o_rsp_valid, o_req_ready);
    end
    tick();
    i_req_valid = '0;
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_result !== 9'h00F) begin
      failures++;
      $display("FAIL bp_second_rsp: valid=%0b id=%0d result=%h required 1 0 00f",
               o_rsp_valid, o_rsp_id, o_rsp_result);
    end
    tick();
  endtask

  task automatic test_pointer_wrap();
    set_ops(3, 8'h01, 8'h02);
    i_req_valid = 4'b1000;
    tick();
    i_req_valid = '0;
    tick();
    tick();
    set_ops(0, 8'h20, 8'h22);
    set_ops(2, 8'h40, 8'h05);
    i_req_valid = 4'b0101;
    #1;
    checks++;
    if (o_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_first: got %b required 0001", o_req_ready);
    end
    tick();
    checks++;
    if (o_req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL wrap_calc_ready: got %b required 0000", o_req_ready);
    end
    tick();
    checks++;
    if (o_rsp_id !== 2'd0 || o_rsp_result !== 9'h042) begin
      failures++;
      $display("FAIL wrap_rsp0: id=%0d result=%h required 0 042", o_rsp_id, o_rsp_result);
    end
    tick();
    checks++;
    if (o_req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_second: got %b required 0100", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    tick();
    checks++;
    if (o_rsp_id !== 2'd2 || o_rsp_result !== 9'h045) begin
      failures++;
      $display("FAIL wrap_rsp2: id=%0d result=%h required 2 045", o_rsp_id, o_rsp_result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_ops(2, 8'h33, 8'h44);
    i_req_valid = 4'b0100;
    #1;
    checks++;
    if (o_req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL rst_mid_grant: got %b required 0100", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_rsp_valid, o_rsp_id, o_rsp_result, o_req_ready} !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid_async: valid=%0b id=%0d result=%h ready=%b required all zero",
               o_rsp_valid, o_rsp_id, o_rsp_result, o_req_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o_rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_no_rsp: cycle %0d valid=%0b required 0", c, o_rsp_valid);
      end
    end
    tick();
    i_req_valid = 4'b1100;
    #1;
    checks++;
    if (o_req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL rst_mid_prio: got %b required 0100", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd2 || o_rsp_result !== 9'h077) begin
      failures++;
      $display("FAIL rst_mid_rsp: valid=%0b id=%0d result=%h required 1 2 077",
               o_rsp_valid, o_rsp_id, o_rsp_result);
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_pointer_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
